// File: rtl/rs15_11_encoder.sv
// -----------------------------------------------------------------------------
// rs15_11_encoder
//   Systematic RS(15,11) encoder over GF(2^4), field polynomial x^4+x+1, t=2.
//   Generator g(x) = x^4 + G3 x^3 + G2 x^2 + G1 x + G0.
//   Message symbols (highest degree first) are passed straight through to the
//   output register while a 4-stage LFSR accumulates the remainder. After
//   K_MSG symbols the four parity symbols are emitted p3,p2,p1,p0.
//   Setting K_MSG below 11 gives a shortened code.
//
// Ports
//   sys_clk     in   clock, rising edge
//   sys_rst_n   in   asynchronous active-low reset (synchronous release upstream)
//   in_data     in   [3:0] message symbol
//   in_valid    in   in_data valid
//   in_ready    out  encoder accepts in_data this cycle
//   out_data    out  [3:0] codeword symbol
//   out_valid   out  out_data valid
//   out_ready   in   downstream accepts out_data
//   out_parity  out  current output symbol is a parity symbol
//   out_last    out  current output symbol is the last of the codeword
// -----------------------------------------------------------------------------
module rs15_11_encoder #(
   parameter int         K_MSG = 11,
   parameter logic [3:0] G0    = 4'd7,
   parameter logic [3:0] G1    = 4'd8,
   parameter logic [3:0] G2    = 4'd12,
   parameter logic [3:0] G3    = 4'd13
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [3:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [3:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_parity,
   output logic       out_last
);

   typedef enum logic {
      ST_MSG    = 1'b0,
      ST_PARITY = 1'b1
   } state_t;

   // GF(16) multiply: carry-less 4x4 product, then fold bits 6..4 back
   // using x^4 = x + 1.
   function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
      logic [6:0] prod;
      prod = '0;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) begin
            prod = prod ^ 7'({3'b000, a} << i);
         end
      end
      for (int k = 6; k >= 4; k--) begin
         if (prod[k]) begin
            prod = prod ^ 7'(7'b0010011 << (k - 4));
         end
      end
      return prod[3:0];
   endfunction

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [3:0][3:0]  par_q, par_d;        // par_q[3] is the highest-degree stage
   logic [3:0]       out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             out_parity_q, out_parity_d;
   logic             out_last_q, out_last_d;
   // Holds in_ready low for the first clock after reset release.
   logic             run_q;

   logic             slot_free;
   logic             accept;
   logic [3:0]       fb;

   // Single-entry output stage: it can be loaded when empty or being drained.
   assign slot_free = !out_valid_q || out_ready;
   assign in_ready  = run_q && (state_q == ST_MSG) && slot_free;
   assign accept    = in_valid && in_ready;
   assign fb        = in_data ^ par_q[3];

   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign out_parity = out_parity_q;
   assign out_last   = out_last_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      par_d        = par_q;
      out_data_d   = out_data_q;
      out_parity_d = out_parity_q;
      out_last_d   = out_last_q;
      out_valid_d  = out_valid_q;

      // Symbol taken downstream and nothing new loaded below: slot empties.
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         ST_MSG: begin
            if (accept) begin
               par_d[3]     = par_q[2] ^ gf_mul(G3, fb);
               par_d[2]     = par_q[1] ^ gf_mul(G2, fb);
               par_d[1]     = par_q[0] ^ gf_mul(G1, fb);
               par_d[0]     = gf_mul(G0, fb);
               out_data_d   = in_data;
               out_valid_d  = 1'b1;
               out_parity_d = 1'b0;
               out_last_d   = 1'b0;
               if (cnt_q == 4'(K_MSG - 1)) begin
                  cnt_d   = '0;
                  state_d = ST_PARITY;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         ST_PARITY: begin
            if (run_q && slot_free) begin
               // Shifting zeros in leaves the LFSR cleared after the 4th symbol.
               out_data_d   = par_q[3];
               out_valid_d  = 1'b1;
               out_parity_d = 1'b1;
               out_last_d   = (cnt_q == 4'd3);
               par_d[3]     = par_q[2];
               par_d[2]     = par_q[1];
               par_d[1]     = par_q[0];
               par_d[0]     = 4'd0;
               if (cnt_q == 4'd3) begin
                  cnt_d   = '0;
                  state_d = ST_MSG;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = ST_MSG;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= ST_MSG;
         cnt_q        <= '0;
         par_q        <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         out_parity_q <= 1'b0;
         out_last_q   <= 1'b0;
         run_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         par_q        <= par_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         out_parity_q <= out_parity_d;
         out_last_q   <= out_last_d;
         run_q        <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rs15_11_encoder.sv
// -----------------------------------------------------------------------------
// tb_rs15_11_encoder
//   Directed bench for rs15_11_encoder: zero message, single-symbol messages
//   with hand-derived parity, random messages under backpressure and input
//   gaps, back-to-back throughput and reset in the middle of a codeword.
//   Codewords are also checked by evaluating syndromes S1..S4.
// -----------------------------------------------------------------------------
module tb_rs15_11_encoder;

   logic       sys_clk;
   logic       sys_rst_n;
   logic [3:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_parity;
   logic       out_last;

   int checks;
   int failures;

   logic [3:0] msg_q[$];   // message symbols to send
   logic [5:0] exp_q[$];   // expected {last, parity, data}
   logic [5:0] got_q[$];   // observed {last, parity, data}
   int         got_cyc[$];

   rs15_11_encoder dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_parity (out_parity),
      .out_last   (out_last)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Shift-and-add GF(16) multiply, x^4 = x + 1.
   function automatic logic [3:0] gfm(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] res;
      logic [3:0] aa;
      res = 4'd0;
      aa  = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) res = res ^ aa;
         aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
      end
      return res;
   endfunction

   // Queue one 11-symbol message; parity by polynomial long division of m(x)x^4 by g(x).
   task automatic add_cw(input logic [43:0] m);
      logic [3:0] r[15];
      logic [3:0] g[5];
      logic [3:0] c;
      g[0] = 4'd1; g[1] = 4'd13; g[2] = 4'd12; g[3] = 4'd8; g[4] = 4'd7;
      for (int i = 0; i < 15; i++) r[i] = 4'd0;
      for (int i = 0; i < 11; i++) begin
         r[i] = m[43 - 4*i -: 4];
         msg_q.push_back(r[i]);
         exp_q.push_back({2'b00, r[i]});
      end
      for (int i = 0; i < 11; i++) begin
         c = r[i];
         for (int j = 0; j < 5; j++) r[i+j] = r[i+j] ^ gfm(c, g[j]);
      end
      for (int i = 11; i < 15; i++) exp_q.push_back({(i == 14), 1'b1, r[i]});
   endtask

   task automatic clear_q();
      msg_q.delete();
      exp_q.delete();
      got_q.delete();
      got_cyc.delete();
   endtask

   task automatic do_reset(input string tag);
      in_valid  = 1'b0;
      in_data   = 4'd0;
      out_ready = 1'b0;
      sys_rst_n = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1;
      check({tag, "_rst_valid"},  32'(out_valid),  32'd0);
      check({tag, "_rst_data"},   32'(out_data),   32'd0);
      check({tag, "_rst_parity"}, 32'(out_parity), 32'd0);
      check({tag, "_rst_last"},   32'(out_last),   32'd0);
      check({tag, "_rst_ready"},  32'(in_ready),   32'd0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      #1;
      check({tag, "_ready_pre"},  32'(in_ready),   32'd0);
      @(posedge sys_clk);
      #1;
      check({tag, "_ready_post"}, 32'(in_ready),   32'd1);
   endtask

   // Send msg_q and collect outputs until all expected symbols arrive.
   task automatic run(input string tag, input int gap_pct, input int stall_pct);
      int         idx;
      int         cyc;
      logic       prev_stall;
      logic [5:0] prev_out;
      idx = 0; cyc = 0; prev_stall = 1'b0; prev_out = '0;
      while ((idx < msg_q.size() || got_q.size() < exp_q.size()) && cyc < 2000) begin
         @(posedge sys_clk);
         #1;
         cyc++;
         if (idx < msg_q.size() && ($urandom_range(99) >= gap_pct)) begin
            in_valid = 1'b1;
            in_data  = msg_q[idx];
         end else begin
            in_valid = 1'b0;
            in_data  = 4'd0;
         end
         out_ready = ($urandom_range(99) >= stall_pct);
         @(negedge sys_clk);
         if (prev_stall) begin
            check({tag, "_stall_hold"}, 32'({out_last, out_parity, out_data}), 32'(prev_out));
            check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
         end
         if (in_valid && in_ready) idx++;
         if (out_valid && out_ready) begin
            got_q.push_back({out_last, out_parity, out_data});
            got_cyc.push_back(cyc);
         end
         prev_stall = out_valid && !out_ready;
         prev_out   = {out_last, out_parity, out_data};
      end
      @(posedge sys_clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check($sformatf("%s_sym%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      end
      // Every complete codeword must have roots a^1..a^4.
      for (int cw = 0; cw + 15 <= got_q.size(); cw += 15) begin
         for (int j = 1; j <= 4; j++) begin
            logic [3:0] aj;
            logic [3:0] s;
            aj = 4'd1;
            for (int k = 0; k < j; k++) aj = gfm(aj, 4'd2);
            s = 4'd0;
            for (int i = 0; i < 15; i++) s = gfm(s, aj) ^ got_q[cw + i][3:0];
            check($sformatf("%s_cw%0d_S%0d", tag, cw / 15, j), 32'(s), 32'd0);
         end
      end
   endtask

   initial begin
      int acc;
      checks    = 0;
      failures  = 0;
      sys_rst_n = 1'b0;
      in_valid  = 1'b0;
      in_data   = 4'd0;
      out_ready = 1'b0;

      do_reset("t0");

      // T1: all-zero message gives an all-zero codeword.
      clear_q();
      add_cw(44'h0);
      run("t1", 0, 0);
      if (got_q.size() == 15) begin
         check("t1_last_flag", 32'(got_q[14][5]), 32'd1);
         check("t1_par_flag",  32'(got_q[11][4]), 32'd1);
      end

      // T2: message 0..0,1 -> parity is x^4 mod g = 13,12,8,7.
      clear_q();
      add_cw(44'h0000000_0001);
      run("t2", 0, 0);
      if (got_q.size() == 15) begin
         check("t2_p3", 32'(got_q[11][3:0]), 32'd13);
         check("t2_p2", 32'(got_q[12][3:0]), 32'd12);
         check("t2_p1", 32'(got_q[13][3:0]), 32'd8);
         check("t2_p0", 32'(got_q[14][3:0]), 32'd7);
      end

      // T2b: message 0..0,1,0 -> x^5 mod g = 2,11,5,5.
      clear_q();
      add_cw(44'h0000000_0010);
      run("t2b", 0, 0);
      if (got_q.size() == 15) begin
         check("t2b_p3", 32'(got_q[11][3:0]), 32'd2);
         check("t2b_p2", 32'(got_q[12][3:0]), 32'd11);
         check("t2b_p1", 32'(got_q[13][3:0]), 32'd5);
         check("t2b_p0", 32'(got_q[14][3:0]), 32'd5);
      end

      // T3: fixed mixed messages, no stalls.
      clear_q();
      add_cw(44'h123_4567_89AB);
      add_cw(44'hFED_CBA9_8765);
      run("t3", 0, 0);

      // T4: random messages under random backpressure and input gaps.
      clear_q();
      for (int n = 0; n < 3; n++) add_cw({$urandom, $urandom} & 44'hFFF_FFFF_FFFF);
      run("t4", 30, 40);

      // T5: back-to-back codewords at full rate, 15 cycles each, no bubbles.
      clear_q();
      add_cw(44'hFFF_FFFF_FFFF);
      add_cw(44'h0000000_0001);
      run("t5", 0, 0);
      if (got_cyc.size() == 30) begin
         check("t5_span", 32'(got_cyc[29] - got_cyc[0]), 32'd29);
         check("t5_cw2_p3", 32'(got_q[26][3:0]), 32'd13);
      end

      // T6: reset after 6 accepted symbols, then a fresh codeword.
      acc = 0;
      for (int c = 0; c < 50 && acc < 6; c++) begin
         @(posedge sys_clk);
         #1;
         in_valid  = 1'b1;
         in_data   = 4'(acc + 5);
         out_ready = 1'b1;
         @(negedge sys_clk);
         if (in_valid && in_ready) acc++;
      end
      check("t6_accepted", 32'(acc), 32'd6);
      @(posedge sys_clk);
      #2;
      in_valid = 1'b0;
      check("t6_pre_valid", 32'(out_valid), 32'd1);
      sys_rst_n = 1'b0;
      #1;
      check("t6_valid_drop", 32'(out_valid), 32'd0);
      check("t6_ready_drop", 32'(in_ready),  32'd0);
      do_reset("t6");
      clear_q();
      add_cw(44'h9A5_3C0F_7E1);
      run("t6", 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
